// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// instruction size and the reset value of the instruction register.
package instr_fetch_pkg;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: sequential increment or load of a redirect target,
// asynchronously reset to RESET_PC.
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        load,
    input  logic [31:0] load_pc,
    output logic [31:0] pc
);

    logic [31:0] pc_next;

    // A load always wins over a sequential advance.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_pc;
        end else if (advance) begin
            pc_next = pc + INSTR_BYTES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one-cycle ROM fetch into a valid/ready output
// register, with redirect, halt and sticky misalignment handling.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          ROM_WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic        rom_read_en,
    output logic        rom_ce,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    logic [1:0]  state_reg, state_next;
    logic        valid_reg, valid_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] opc_reg, opc_next;
    logic        err_reg, err_next;
    logic        pc_advance, pc_load;
    logic [31:0] pc;
    logic        transfer, slot_free;
    logic        unused_pc_bits;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (pc_advance),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .pc      (pc)
    );

    assign transfer  = valid_reg && out_ready;
    assign slot_free = !valid_reg || out_ready;

    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        instr_next = instr_reg;
        opc_next   = opc_reg;
        err_next   = err_reg;
        pc_advance = 1'b0;
        pc_load    = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // Any redirect squashes the held instruction; a bad target stops the core for good.
                    valid_next = 1'b0;
                    if (is_aligned(redirect_pc)) begin
                        pc_load = 1'b1;
                        if (halt) begin
                            state_next = ST_HALTED;
                        end
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_HALTED;
                    end
                end else if (halt) begin
                    state_next = ST_HALTED;
                    if (transfer) begin
                        valid_next = 1'b0;
                    end
                end else if (slot_free) begin
                    instr_next = rom_data;
                    opc_next   = pc;
                    valid_next = 1'b1;
                    pc_advance = 1'b1;
                end
            end
            ST_HALTED: begin
                if (transfer) begin
                    valid_next = 1'b0;
                end
                if (!halt && !err_reg) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
            opc_reg   <= 32'h0000_0000;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            instr_reg <= instr_next;
            opc_reg   <= opc_next;
            err_reg   <= err_next;
        end
    end

    assign rom_ce      = (state_reg == ST_RUN);
    assign rom_read_en = rom_ce && slot_free;

    // Word address bits beyond the ROM depth are tied low; the bus is idle outside RUN.
    for (genvar gi = 0; gi < 32; gi++) begin : g_rom_addr
        if ((gi < ROM_WORDS_LOG2) && (gi < 30)) begin : g_used
            assign rom_address[gi] = pc[gi+2] & rom_ce;
        end else begin : g_zero
            assign rom_address[gi] = 1'b0;
        end
    end

    assign unused_pc_bits = ^pc;

    assign out_valid    = valid_reg;
    assign out_instr    = instr_reg;
    assign out_pc       = opc_reg;
    assign misalign_err = err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus random stimulus for instr_fetch, checked each cycle against
// a behavioural model of the fetch rules.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_ready;

    logic [31:0] rom_address, rom_data, out_instr, out_pc;
    logic        rom_read_en, rom_ce, out_valid, misalign_err;

    logic [31:0] rom_address2, rom_data2, out_instr2, out_pc2;
    logic        rom_read_en2, rom_ce2, out_valid2, misalign_err2;

    logic [31:0] rom [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: booting / fetching / dead (misaligned) flags plus pc and output register.
    bit          m_boot, m_run, m_dead, m_valid;
    logic [31:0] m_pc, m_instr, m_opc;

    always #5 clk = ~clk;

    assign rom_data  = rom[rom_address[9:0]];
    assign rom_data2 = rom[rom_address2[9:0]];

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .rom_read_en    (rom_read_en),
        .rom_ce         (rom_ce),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    instr_fetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address2),
        .rom_data       (rom_data2),
        .rom_read_en    (rom_read_en2),
        .rom_ce         (rom_ce2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid2),
        .out_ready      (out_ready),
        .out_instr      (out_instr2),
        .out_pc         (out_pc2),
        .misalign_err   (misalign_err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_run   = 1'b0;
        m_dead  = 1'b0;
        m_valid = 1'b0;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_opc   = 32'h0;
    endtask

    // Applies one clock edge worth of fetch rules using the inputs currently driven.
    task automatic model_edge();
        bit taken;
        taken = m_valid && out_ready;
        if (m_boot) begin
            m_boot = 1'b0;
            m_run  = 1'b1;
        end else if (m_run) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                if (redirect_pc % 4 != 0) begin
                    m_dead = 1'b1;
                    m_run  = 1'b0;
                end else begin
                    m_pc  = redirect_pc;
                    m_run = !halt;
                end
            end else if (halt) begin
                m_run = 1'b0;
                if (taken) m_valid = 1'b0;
            end else if (!m_valid || out_ready) begin
                m_instr = rom[(m_pc / 4) % 1024];
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end else begin
            if (taken) m_valid = 1'b0;
            if (!halt && !m_dead) m_run = 1'b1;
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".valid"}, {31'b0, out_valid}, {31'b0, m_valid});
        check({where, ".err"}, {31'b0, misalign_err}, {31'b0, m_dead});
        check({where, ".ce"}, {31'b0, rom_ce}, {31'b0, m_run});
        check({where, ".rd_en"}, {31'b0, rom_read_en}, {31'b0, m_run && (!m_valid || out_ready)});
        if (m_valid) begin
            check({where, ".instr"}, out_instr, m_instr);
            check({where, ".pc"}, out_pc, m_opc);
        end
        if (m_run) begin
            check({where, ".addr"}, rom_address, (m_pc / 4) % 1024);
        end
    endtask

    task automatic step(input string where);
        model_edge();
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.err", {31'b0, misalign_err}, 32'd0);
        check("rst.ce", {31'b0, rom_ce}, 32'd0);
        check("rst.rd_en", {31'b0, rom_read_en}, 32'd0);
        check("rst.addr", rom_address, 32'd0);
        check("rst.instr", out_instr, 32'd0);
        check("rst.pc", out_pc, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;

        @(negedge clk);
        do_reset();

        // Boot cycle, then A and B back to back; the wrapping instance starts at the top of memory.
        step("boot");
        step("fetch_a");
        check("wrap.first_pc", out_pc2, 32'hFFFF_FFFC);
        check("wrap.first_instr", out_instr2, rom[1023]);
        step("fetch_b");
        check("wrap.second_pc", out_pc2, 32'h0000_0000);
        check("wrap.second_instr", out_instr2, rom[0]);

        out_ready = 1'b0;
        repeat (3) step("stall_b");
        check("stall.hold_pc", out_pc, 32'h4);
        out_ready = 1'b1;
        step("fetch_c");
        check("after_stall.pc", out_pc, 32'h8);
        step("fetch_d");

        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step("redirect");
        redirect_valid = 1'b0;
        step("target");
        check("target.instr", out_instr, rom[16]);

        halt      = 1'b1;
        out_ready = 1'b0;
        repeat (5) step("halted_hold");
        halt      = 1'b0;
        out_ready = 1'b1;
        step("unhalt");
        step("resume");
        check("resume.pc", out_pc, 32'h44);

        for (int i = 0; i < 300; i++) begin
            out_ready      = ($urandom_range(0, 9) < 7);
            halt           = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
                                                         : 32'($urandom_range(0, 1023)) << 2;
            step("random");
        end
        halt           = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        step("settle");

        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step("misalign");
        redirect_valid = 1'b0;
        halt           = 1'b1;
        step("dead_halt");
        halt = 1'b0;
        repeat (3) step("dead_release");
        check("dead.ce", {31'b0, rom_ce}, 32'd0);

        #2;
        do_reset();
        repeat (4) step("restart");
        #2;
        do_reset();
        repeat (6) step("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter ROM_WORDS_LOG2, default 10: number of word-address bits actually driven to the ROM.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rom_address  output  32  ROM word address, equal to {2'b00, pc[31:2]}.
REQ-006 rom_data  input  32  ROM read data, combinational from rom_address in the same cycle.
REQ-007 rom_read_en  output  1  ROM read enable.
REQ-008 rom_ce  output  1  ROM chip enable.
REQ-009 redirect_valid  input  1  branch/jump taken this cycle.
REQ-010 redirect_pc  input  32  target byte address.
REQ-011 halt  input  1  level request to stop fetching.
REQ-012 out_valid  output  1  instruction register holds a valid instruction.
REQ-013 out_ready  input  1  decode stage accepts the instruction.
REQ-014 out_instr  output  32  fetched instruction.
REQ-015 out_pc  output  32  byte address of out_instr.
REQ-016 misalign_err  output  1  sticky; set when redirect_pc[1:0] != 0.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN and HALTED.
REQ-018 BOOT lasts exactly one cycle after reset release, then moves to RUN; no ROM access occurs in BOOT.
REQ-019 In RUN, rom_ce=1 every cycle; rom_read_en=1 only when the output register is free (!out_valid || out_ready).
REQ-020 A fetch SHALL capture rom_data into out_instr and pc into out_pc at the same edge, set out_valid=1 and advance pc by 4: one-cycle latency, one instruction per cycle sustained.
REQ-021 Handshake: a transfer occurs when out_valid && out_ready; while out_valid && !out_ready, out_instr, out_pc and pc SHALL hold stable.
REQ-022 Redirect has highest priority in RUN. On redirect_valid with aligned redirect_pc, the block SHALL set pc <= redirect_pc and out_valid <= 0, and SHALL not capture an instruction that cycle; the first instruction from the target appears one cycle later.
REQ-023 A redirect with redirect_pc[1:0] != 0 SHALL set misalign_err, clear out_valid and enter HALTED; pc is left unchanged.
REQ-024 halt=1 in RUN (with no redirect) SHALL enter HALTED at the next edge. A pending out_valid SHALL remain until it is accepted; no new fetch is issued.
REQ-025 In HALTED, rom_ce=0 and rom_read_en=0. Deasserting halt SHALL return to RUN unless misalign_err=1; misalign_err is cleared only by reset.
REQ-026 pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0). rom_address bits at and above ROM_WORDS_LOG2 SHALL be zero.
REQ-027 When redirect and halt are asserted in the same cycle, the redirect is applied and the block then enters HALTED.

Reset
REQ-028 While rst_n=0: state=BOOT, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, rom_ce=0, rom_read_en=0, rom_address=0.
REQ-029 Reset asserted mid-fetch or mid-stall SHALL clear state immediately, without waiting for clk; any in-flight instruction is discarded.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (2 bits), the constant INSTR_BYTES=4 and the NOP encoding 32'h0000_0000.
REQ-031 The single sub-module is pc_reg: the PC register with increment, redirect mux and async reset.

Verification
REQ-032 Reset release, ROM[0..3]=A,B,C,D, out_ready=1 -> out_valid rises in cycle 2 (BOOT in cycle 1); A,B,C,D appear with out_pc 0,4,8,C, one per cycle.
REQ-033 out_ready=0 for 3 cycles while out_instr=B -> out_instr/out_pc hold B/4, rom_read_en=0; after release, C/8 follows.
REQ-034 redirect_valid with redirect_pc=0x40 while out_instr=B -> next cycle out_valid=0; following cycle out_instr=ROM[0x10], out_pc=0x40.
REQ-035 redirect_pc=0x42 -> misalign_err=1, out_valid=0, rom_ce=0; deasserting halt does not resume fetching; only rst_n restores operation.
REQ-036 halt=1 for 5 cycles with out_ready=0 -> pending instruction held, rom_ce=0; after halt=0 and out_ready=1, fetch resumes at the next sequential pc.
REQ-037 RESET_PC=32'hFFFF_FFFC -> first out_pc=FFFF_FFFC, second out_pc=0; rst_n pulsed low mid-stream between edges -> out_valid drops immediately.
